gmt_cmd_dispatch: RTL

Initiator for the geometry engine's command handshake: buffers CPU-side geometry commands in a small FIFO and issues them one at a time over the matrix unit's go/busy interface. Drives operand buses (v0–v7, object type/color/number, gmt_op/gmt_code) and a one-cycle `go`, then tracks `busy` to completion. Captures the matrix unit's memory-full and last-stored-object status per command. Sits between the CPU register interface and the matrix unit top.

---
 rtl/gmt_cmd_dispatch.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/gmt_cmd_dispatch.sv
// gmt_cmd_dispatch: command FIFO feeding the matrix unit's go/busy start interface.
// Optional feature: define GMT_DISPATCH_TIMEOUT_EN to enable the go-to-busy timeout.
module gmt_cmd_dispatch #(
  parameter int DEPTH      = 4,
  parameter int TMO_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_wr,
  input  logic [127:0] cmd_v,
  input  logic [1:0]   cmd_type,
  input  logic [7:0]   cmd_color,
  input  logic [4:0]   cmd_obj_num,
  input  logic [3:0]   cmd_op,
  input  logic [3:0]   cmd_code,
  output logic         cmd_full,
  output logic         cmd_empty,
  output logic         cmd_ovf,
  output logic         go,
  output logic [15:0]  v0,
  output logic [15:0]  v1,
  output logic [15:0]  v2,
  output logic [15:0]  v3,
  output logic [15:0]  v4,
  output logic [15:0]  v5,
  output logic [15:0]  v6,
  output logic [15:0]  v7,
  output logic [1:0]   obj_type,
  output logic [7:0]   obj_color,
  output logic [4:0]   obj_num_in,
  output logic [3:0]   gmt_op,
  output logic [3:0]   gmt_code,
  input  logic         busy,
  input  logic         obj_mem_full_out,
  input  logic [4:0]   lst_stored_obj_out,
  output logic         sts_vld,
  output logic         sts_mem_full,
  output logic [4:0]   sts_lst_obj,
  output logic         tmo_err,
  output logic [7:0]   done_cnt,
  output logic         idle,
  output logic [1:0]   dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TMO_CYCLES < 2) || (TMO_CYCLES > 256)) begin : g_bad_param
    $error("gmt_cmd_dispatch: DEPTH must be a power of two >= 2, TMO_CYCLES in 2..256");
  end

  typedef struct packed {
    logic [127:0] v;
    logic [1:0]   typ;
    logic [7:0]   color;
    logic [4:0]   num;
    logic [3:0]   op;
    logic [3:0]   code;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cmd_t        mem_q [DEPTH];
  cmd_t        ops_q, ops_d, wr_cmd;
  logic        cmd_ovf_q, cmd_ovf_d;
  logic        sts_vld_q, sts_vld_d;
  logic        sts_mem_full_q, sts_mem_full_d;
  logic [4:0]  sts_lst_obj_q, sts_lst_obj_d;
  logic [7:0]  done_cnt_q, done_cnt_d;
  logic        push, full, empty;

`ifdef GMT_DISPATCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       tmo_err_q, tmo_err_d;
  assign tmo_err = tmo_err_q;
`else
  assign tmo_err = 1'b0;
`endif

  assign wr_cmd = {cmd_v, cmd_type, cmd_color, cmd_obj_num, cmd_op, cmd_code};
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push   = cmd_wr && !full;

  // Handshake: go is high for the single ISSUE cycle; busy is only looked at from
  // WAIT_BUSY onward, and its falling edge (sampled low in WAIT_DONE) completes the command.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    ops_d          = ops_q;
    cmd_ovf_d      = cmd_ovf_q | (cmd_wr & full);
    sts_vld_d      = 1'b0;
    sts_mem_full_d = sts_mem_full_q;
    sts_lst_obj_d  = sts_lst_obj_q;
    done_cnt_d     = done_cnt_q;
`ifdef GMT_DISPATCH_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    tmo_err_d      = tmo_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          ops_d    = mem_q[rd_ptr_q[AW-1:0]];
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
`ifdef GMT_DISPATCH_TIMEOUT_EN
        // The ISSUE cycle counts as the first cycle after go.
        tmo_cnt_d = 8'd1;
`endif
      end
      S_WAIT_BUSY: begin
        if (busy) begin
          state_d = S_WAIT_DONE;
        end
`ifdef GMT_DISPATCH_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      S_WAIT_DONE: begin
        if (!busy) begin
          sts_vld_d      = 1'b1;
          sts_mem_full_d = obj_mem_full_out;
          sts_lst_obj_d  = lst_stored_obj_out;
          done_cnt_d     = done_cnt_q + 8'd1;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      ops_q          <= '0;
      cmd_ovf_q      <= 1'b0;
      sts_vld_q      <= 1'b0;
      sts_mem_full_q <= 1'b0;
      sts_lst_obj_q  <= '0;
      done_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      ops_q          <= ops_d;
      cmd_ovf_q      <= cmd_ovf_d;
      sts_vld_q      <= sts_vld_d;
      sts_mem_full_q <= sts_mem_full_d;
      sts_lst_obj_q  <= sts_lst_obj_d;
      done_cnt_q     <= done_cnt_d;
    end
  end

`ifdef GMT_DISPATCH_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end
`endif

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_cmd;
    end
  end

  assign cmd_full     = full;
  assign cmd_empty    = empty;
  assign cmd_ovf      = cmd_ovf_q;
  assign go           = (state_q == S_ISSUE);
  assign v0           = ops_q.v[15:0];
  assign v1           = ops_q.v[31:16];
  assign v2           = ops_q.v[47:32];
  assign v3           = ops_q.v[63:48];
  assign v4           = ops_q.v[79:64];
  assign v5           = ops_q.v[95:80];
  assign v6           = ops_q.v[111:96];
  assign v7           = ops_q.v[127:112];
  assign obj_type     = ops_q.typ;
  assign obj_color    = ops_q.color;
  assign obj_num_in   = ops_q.num;
  assign gmt_op       = ops_q.op;
  assign gmt_code     = ops_q.code;
  assign sts_vld      = sts_vld_q;
  assign sts_mem_full = sts_mem_full_q;
  assign sts_lst_obj  = sts_lst_obj_q;
  assign done_cnt     = done_cnt_q;
  assign idle         = (state_q == S_IDLE) && empty;
  assign dbg_state    = state_q;

endmodule
